// File: rtl/rr_arb8_seg.sv
// Eight-way round-robin arbiter with request/done handshake and an active-low
// seven-segment display of the current owner. Optional feature macro: ARB_TIMEOUT_EN.
module rr_arb8_seg #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic       gnt_valid,
   output logic [2:0] gnt_id,
   output logic [6:0] h
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t     state_r, state_s;
   logic [2:0] last_r;
   logic [7:0] gnt_r;
   logic       gnt_valid_r;
   logic [2:0] gnt_id_r;
   logic [3:0] pick_s;
   logic       release_s;
   logic       timeout_s;

   // Lowest offset from last wins; offset 8 (last itself) has the lowest priority.
   function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] from_last);
      logic [3:0] res;
      logic [2:0] idx;
      res = 4'b0000;
      for (int k = 8; k >= 1; k--) begin
         idx = from_last + 3'(k);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // Segment pattern {a..g}, active-high before inversion.
   function automatic logic [6:0] seg_code(input logic [2:0] id);
      logic [6:0] code;
      case (id)
         3'd0:    code = 7'b1111110;
         3'd1:    code = 7'b0110000;
         3'd2:    code = 7'b1101101;
         3'd3:    code = 7'b1111001;
         3'd4:    code = 7'b0110011;
         3'd5:    code = 7'b1011011;
         3'd6:    code = 7'b1011111;
         3'd7:    code = 7'b1110000;
         default: code = 7'b0000000;
      endcase
      return code;
   endfunction

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
      $error("rr_arb8_seg: HOLD_MAX out of range 1..255");
   end

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_cnt_r;

   // Grant-length counter; held at zero while idle so each grant starts fresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_r <= 8'd0;
      end else if (state_r == GRANT) begin
         hold_cnt_r <= hold_cnt_r + 8'd1;
      end else begin
         hold_cnt_r <= 8'd0;
      end
   end

   assign timeout_s = (state_r == GRANT) && (hold_cnt_r == 8'(HOLD_MAX - 1));
`else
   assign timeout_s = 1'b0;
`endif

   assign pick_s    = rr_pick(req, last_r);
   assign release_s = done | ~req[gnt_id_r] | ~en | timeout_s;

   // Next-state selection for the two-state grant FSM.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (en && pick_s[3]) begin
               state_s = GRANT;
            end else begin
               state_s = IDLE;
            end
         end
         GRANT: begin
            if (release_s) begin
               state_s = IDLE;
            end else begin
               state_s = GRANT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State and grant registers; grant fields always change on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         last_r      <= 3'd7;
         gnt_r       <= 8'h00;
         gnt_valid_r <= 1'b0;
         gnt_id_r    <= 3'd0;
      end else begin
         state_r <= state_s;
         if (state_r == IDLE && state_s == GRANT) begin
            gnt_r       <= 8'd1 << pick_s[2:0];
            gnt_valid_r <= 1'b1;
            gnt_id_r    <= pick_s[2:0];
            last_r      <= pick_s[2:0];
         end else if (state_r == GRANT && state_s == IDLE) begin
            gnt_r       <= 8'h00;
            gnt_valid_r <= 1'b0;
         end
      end
   end

   // Display decode from registered state only; blank while idle.
   always_comb begin
      if (gnt_valid_r) begin
         h = ~seg_code(gnt_id_r);
      end else begin
         h = 7'h7F;
      end
   end

   assign gnt       = gnt_r;
   assign gnt_valid = gnt_valid_r;
   assign gnt_id    = gnt_id_r;

endmodule

// File: tb/tb_rr_arb8_seg.sv
// Directed self-checking bench for rr_arb8_seg (timeout checks built when
// ARB_TIMEOUT_EN is defined, with HOLD_MAX = 4).
module tb_rr_arb8_seg;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic       gnt_valid;
   logic [2:0] gnt_id;
   logic [6:0] h;

   int chk_cnt;
   int pass_cnt;

   logic [6:0] h_exp [8];

   rr_arb8_seg #(.HOLD_MAX(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .h         (h)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_grant(input string tag, input logic [2:0] id);
      logic [7:0] one_hot;
      one_hot = 8'd1 << id;
      check_eq({tag, "_valid"}, 32'(gnt_valid), 32'd1);
      check_eq({tag, "_id"},    32'(gnt_id),    32'(id));
      check_eq({tag, "_gnt"},   32'(gnt),       32'(one_hot));
      check_eq({tag, "_h"},     32'(h),         32'(h_exp[id]));
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_valid"}, 32'(gnt_valid), 32'd0);
      check_eq({tag, "_gnt"},   32'(gnt),       32'd0);
      check_eq({tag, "_h"},     32'(h),         32'h7F);
   endtask

   initial begin
      h_exp[0] = 7'h01; h_exp[1] = 7'h4F; h_exp[2] = 7'h12; h_exp[3] = 7'h06;
      h_exp[4] = 7'h4C; h_exp[5] = 7'h24; h_exp[6] = 7'h20; h_exp[7] = 7'h0F;
      chk_cnt  = 0;
      pass_cnt = 0;
      rst_n = 1'b0;
      en    = 1'b1;
      req   = 8'h00;
      done  = 1'b0;

      // reset state
      #3;
      check_idle("rst");
      check_eq("rst_id", 32'(gnt_id), 32'd0);
      rst_n = 1'b1;
      step();
      check_idle("idle_noreq");

      // first grant: requester 4
      req = 8'h10;
      step();
      check_grant("first4", 3'd4);
      req = 8'h00;
      step();
      check_idle("drop_rel");
      check_eq("drop_hold_id", 32'(gnt_id), 32'd4);

      // all requesting with done held: 5,6,7,0..5 with one idle cycle each
      req  = 8'hFF;
      done = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         check_grant($sformatf("rot%0d", i), 3'((5 + i) % 8));
         step();
         check_idle($sformatf("rot_idle%0d", i));
      end

      // grant to 3, then bits 1 and 3: rotation from 4 wraps to 1
      done = 1'b0;
      req  = 8'h08;
      step();
      check_grant("g3", 3'd3);
      req  = 8'h0A;
      done = 1'b1;
      step();
      check_idle("g3_rel");
      step();
      check_grant("wrap1", 3'd1);
      step();
      check_idle("wrap1_rel");
      step();
      check_grant("then3", 3'd3);

      // enable low releases and blocks new grants
      done = 1'b0;
      en   = 1'b0;
      step();
      check_idle("en_rel");
      req = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         check_idle($sformatf("en_block%0d", i));
      end
      en = 1'b1;
      step();
      check_grant("en_back4", 3'd4);
      req = 8'h00;
      step();
      check_idle("en_back_rel");

      // single requester held, done low
      req = 8'h01;
      step();
      check_grant("hold0", 3'd0);
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         step();
         check_grant($sformatf("to_hold%0d", i), 3'd0);
      end
      step();
      check_idle("to_rel");
      step();
      check_grant("to_regrant", 3'd0);
`else
      for (int i = 0; i < 10; i++) begin
         step();
         check_grant($sformatf("no_to%0d", i), 3'd0);
      end
`endif

      // asynchronous reset mid-grant, then last restarts at 7
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_rst");
      check_eq("async_rst_id", 32'(gnt_id), 32'd0);
      req = 8'h81;
      #1;
      rst_n = 1'b1;
      step();
      check_grant("post_rst0", 3'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/rr_arb8_seg.md
# rr_arb8_seg

Round-robin arbiter that shares one downstream resource among eight requesters and shows the current owner on a seven-segment digit. It sits in front of the `encode83`-style display path. The combinational priority encoder is replaced by a registered, fair, rotating-priority grant FSM with a request/done handshake. The seven-segment output uses the same active-low encoding as the team's `bcd7seg`.

## Interface
Parameters:
- `HOLD_MAX`, default 15: maximum grant length in cycles when the timeout feature is compiled in. Legal range 1..255.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `en`, input, 1: arbiter enable. Low forces release and blocks new grants.
- `req`, input, 8: request vector, bit i = requester i. Level-held until served.
- `done`, input, 1: the current owner finished. Sampled only in GRANT.
- `gnt`, output, 8: one-hot grant, registered. All zero when idle.
- `gnt_valid`, output, 1: a grant is active, registered.
- `gnt_id`, output, 3: binary index of the owner, registered. Holds its last value when idle.
- `h`, output, 7: active-low seven-segment code of `gnt_id`, ordered {a,b,c,d,e,f,g} from MSB to LSB. Equals 7'h7F (blank) when `gnt_valid`=0.

## Operation
- The FSM has two states, IDLE and GRANT. A 3-bit register `last` holds the most recently granted index. An 8-bit counter `hold_cnt` exists only with the macro (see Configuration).
- IDLE:
  - If `en`=1 and `req`≠0, select the first set bit scanning upward from index (`last`+1) mod 8 and wrapping through 7→0.
  - On the next edge: set `gnt`, `gnt_id` and `last` to that index, set `gnt_valid`=1, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: the grant is released at the next edge if any of these is true:
  - `done`=1
  - `req[gnt_id]`=0
  - `en`=0
  - timeout, with the macro only
- On release: `gnt` is cleared, `gnt_valid` is cleared, and the FSM goes to IDLE. `gnt_id` and `last` are kept.
- Simultaneous events:
  - A new request arriving in the release cycle is not granted in that cycle. IDLE always lasts at least one cycle between grants.
  - `done` together with `en`=0 is one release, not two.
- Fairness: the requester just served has the lowest priority in the next arbitration. With all eight bits held, the grant order is 0,1,…,7,0,…
- Seven-segment codes, before inversion:
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - `h` is the bitwise inverse of the code. `h` is combinational from the registered `gnt_id`/`gnt_valid` only.

## Timing
- Reset values (while `rst_n`=0):
  - `gnt`=8'h00
  - `gnt_valid`=0
  - `gnt_id`=3'd0
  - `h`=7'h7F
  - `last`=3'd7, so the first scan starts at index 0
  - `hold_cnt`=0
  - state = IDLE
- Reset asserted mid-grant drops the grant asynchronously, with no handshake.
- Grant latency: a request sampled at edge k in IDLE gives `gnt` valid immediately after edge k.
- Release latency: a release condition sampled at edge k in GRANT gives `gnt`=0 after edge k.
- Minimum cycle per grant: 1 cycle GRANT + 1 cycle IDLE.
- `gnt`, `gnt_valid` and `gnt_id` change only together, on the same edge.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - `hold_cnt` increments every GRANT cycle.
  - The grant is force-released at the edge ending its `HOLD_MAX`-th GRANT cycle, even if `req` and `en` remain high and `done`=0.
  - The preempted requester drops to lowest priority.
- Undefined:
  - No counter is built and `HOLD_MAX` is ignored.
  - A grant lasts until `done`, a request drop, or `en`=0.

## Test plan
- Reset release with `req`=8'h00, `en`=1 → `gnt_valid`=0, `h`=7'h7F. Then `req`=8'h10 → after one edge `gnt`=8'h10, `gnt_id`=4, `h`=~7'b0110011.
- `req`=8'hFF held, `done` pulsed in each GRANT cycle → `gnt_id` sequence 0,1,2,…,7,0 with exactly one idle cycle between grants.
- Grant to 3, then `req`=8'h0A (bits 1 and 3) → after 3 releases, the next grant is 1, not 3. Rotation starts from `last`+1=4 and wraps to 1.
- Grant active, `en` driven 0 → `gnt`=0 next edge. With `en`=0 held and `req`=8'hFF, no grant is issued.
- With `ARB_TIMEOUT_EN`, `HOLD_MAX`=4, `req`=8'h01 held, `done`=0 → `gnt_valid` high exactly 4 cycles, low 1 cycle, then regranted to 0.
- `rst_n` asserted asynchronously mid-grant (between edges) → `gnt`=0 and `h`=7'h7F immediately. After release, with `req`=8'h81 (bits 0 and 7), the first grant is 0.
